// File: rtl/uart_cpu_core_if.sv
// Bus bundle between uart_cpu_core and its surroundings: instruction ROM,
// uart_rx/uart_tx byte handshakes, status flags and the debug register port.
interface uart_cpu_core_if #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 8
);
    logic [PC_W-1:0]   instr_addr;
    logic [15:0]       instr_data;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic              tx_ready;
    logic              halted;
    logic              rx_overflow;
    logic [1:0]        dbg_sel;
    logic [DATA_W-1:0] dbg_data;

    modport master (
        output instr_addr,
        input  instr_data,
        input  rx_valid,
        input  rx_data,
        output tx_valid,
        output tx_data,
        input  tx_ready,
        output halted,
        output rx_overflow,
        input  dbg_sel,
        output dbg_data
    );

    modport slave (
        input  instr_addr,
        output instr_data,
        output rx_valid,
        output rx_data,
        input  tx_valid,
        input  tx_data,
        output tx_ready,
        input  halted,
        input  rx_overflow,
        output dbg_sel,
        input  dbg_data
    );
endinterface

// File: rtl/uart_cpu_core.sv
// Multi-cycle 4-register CPU core: FETCH/EXEC state machine, receive FIFO
// feeding IN, handshaked OUT towards the transmitter, jumps and HALT.
module uart_cpu_core #(
    parameter int DATA_W   = 8,
    parameter int PC_W     = 8,
    parameter int RX_DEPTH = 4
) (
    input logic             clk,
    input logic             rst,
    uart_cpu_core_if.master bus
);
    localparam int PTR_W = $clog2(RX_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RX_DEPTH);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_LDI  = 4'h6;
    localparam logic [3:0] OP_ADDI = 4'h7;
    localparam logic [3:0] OP_IN   = 4'h8;
    localparam logic [3:0] OP_OUT  = 4'h9;
    localparam logic [3:0] OP_JZ   = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH,
        S_EXEC,
        S_WAIT_IN,
        S_WAIT_OUT,
        S_HALT
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [15:0]       ir_q;
    logic [DATA_W-1:0] regs [4];
    logic              tx_valid_q;
    logic [7:0]        tx_data_q;
    logic              halted_q;
    logic              ovf_q;

    logic [7:0]        fifo_mem [RX_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]  count_q;

    logic              ir_load, reg_we, pop, push, tx_load, tx_clr, halt_set;
    logic [DATA_W-1:0] reg_wd;

    logic [3:0]        op;
    logic [1:0]        rd, rs;
    logic [DATA_W-1:0] imm_d;
    logic [PC_W-1:0]   imm_pc;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;

    function automatic logic [DATA_W-1:0] alu_result(
        input logic [3:0]        opc,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic [DATA_W-1:0] imm
    );
        case (opc)
            OP_ADD:  alu_result = a + b;
            OP_SUB:  alu_result = a - b;
            OP_AND:  alu_result = a & b;
            OP_OR:   alu_result = a | b;
            OP_XOR:  alu_result = a ^ b;
            OP_LDI:  alu_result = imm;
            OP_ADDI: alu_result = a + imm;
            default: alu_result = a;
        endcase
    endfunction

    assign op         = ir_q[15:12];
    assign rd         = ir_q[11:10];
    assign rs         = ir_q[9:8];
    assign imm_d      = DATA_W'(ir_q[7:0]);
    assign imm_pc     = PC_W'(ir_q[7:0]);
    assign fifo_empty = (count_q == '0);
    assign fifo_head  = DATA_W'(fifo_mem[rd_ptr_q]);

    // A full FIFO still accepts a byte when the core pops in the same cycle.
    assign push = bus.rx_valid && ((count_q < DEPTH_C) || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_load  = 1'b0;
        reg_we   = 1'b0;
        reg_wd   = '0;
        pop      = 1'b0;
        tx_load  = 1'b0;
        tx_clr   = 1'b0;
        halt_set = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_load = 1'b1;
                pc_d    = pc_q + PC_W'(1);
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LDI, OP_ADDI: begin
                        reg_we = 1'b1;
                        reg_wd = alu_result(op, regs[rd], regs[rs], imm_d);
                    end
                    OP_IN: begin
                        if (!fifo_empty) begin
                            pop    = 1'b1;
                            reg_we = 1'b1;
                            reg_wd = fifo_head;
                        end else begin
                            state_d = S_WAIT_IN;
                        end
                    end
                    OP_OUT: begin
                        tx_load = 1'b1;
                        state_d = S_WAIT_OUT;
                    end
                    OP_JZ:  if (regs[rd] == '0) pc_d = imm_pc;
                    OP_JMP: pc_d = imm_pc;
                    OP_HALT: begin
                        halt_set = 1'b1;
                        state_d  = S_HALT;
                    end
                    default: ;
                endcase
            end
            S_WAIT_IN: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    reg_we  = 1'b1;
                    reg_wd  = fifo_head;
                    state_d = S_FETCH;
                end
            end
            S_WAIT_OUT: begin
                if (tx_valid_q && bus.tx_ready) begin
                    tx_clr  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= '0;
            ir_q       <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            halted_q   <= 1'b0;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            pc_q <= pc_d;
            if (ir_load) ir_q <= bus.instr_data;
            if (reg_we)  regs[rd] <= reg_wd;
            if (tx_load) begin
                tx_valid_q <= 1'b1;
                tx_data_q  <= regs[rs][7:0];
            end else if (tx_clr) begin
                tx_valid_q <= 1'b0;
            end
            if (halt_set) halted_q <= 1'b1;
        end
    end

    // Receive FIFO control; storage below is left unreset since count gates it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_q <= count_q + CNT_W'(1);
            else if (pop && !push) count_q <= count_q - CNT_W'(1);
            if (bus.rx_valid && !push) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= bus.rx_data;
    end

    assign bus.instr_addr  = pc_q;
    assign bus.tx_valid    = tx_valid_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.halted      = halted_q;
    assign bus.rx_overflow = ovf_q;
    assign bus.dbg_data    = regs[bus.dbg_sel];
endmodule

// File: doc/uart_cpu_core.md
Name: uart_cpu_core

Overview:
Parametrised multi-cycle register CPU core with byte-stream I/O. It replaces the free-running single-cycle datapath with a FETCH/EXEC state machine, adds a receive FIFO with IN/OUT instructions that stall on handshakes, and adds jumps and a HALT instruction. It sits between the instruction ROM and the existing uart_rx/uart_tx modules, which are instantiated one level up.

Parameters:
DATA_W, 8, register/ALU/IO data width; must be >= 8.
PC_W, 8, program counter width; must be >= 8.
RX_DEPTH, 4, receive FIFO depth in entries; power of two, >= 2.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
instr_addr  out  PC_W  instruction memory address (= pc), combinational ROM
instr_data  in  16  instruction word returned for instr_addr, same cycle
rx_valid  in  1  one-cycle pulse: rx_data holds a received byte (uart_rx data_ready)
rx_data  in  8  received byte, zero-extended to DATA_W on push
tx_valid  out  1  tx_data holds a byte to send
tx_data  out  8  low 8 bits of the OUT source register
tx_ready  in  1  transmitter can accept a byte (= !busy of uart_tx)
halted  out  1  core has executed HALT
rx_overflow  out  1  sticky: a received byte was dropped
dbg_sel  in  2  debug register select
dbg_data  out  DATA_W  combinational read of register dbg_sel

Behaviour:
- Four registers r0..r3, DATA_W bits each. Instruction fields: [15:12] op, [11:10] rd, [9:8] rs, [7:0] imm. imm is zero-extended to DATA_W or PC_W.
- Opcodes: 0 NOP; 1 ADD rd+=rs; 2 SUB rd-=rs; 3 AND; 4 OR; 5 XOR; 6 LDI rd=imm; 7 ADDI rd+=imm; 8 IN rd<=FIFO head; 9 OUT send rs; A JZ: if rd==0 then pc=imm; B JMP pc=imm; F HALT; C,D,E execute as NOP.
- Arithmetic is modulo 2^DATA_W. No flags.
- Reset: pc=0, all registers 0, state FETCH, FIFO empty, tx_valid=0, tx_data=0, halted=0, rx_overflow=0. Reset is asynchronous and applies in any state, including mid-stall; tx_valid drops immediately.
- States:
  - FETCH: IR<=instr_data; pc<=pc+1, wrapping 2^PC_W-1 -> 0; go to EXEC.
  - EXEC: execute IR. ALU ops, LDI, NOP, JMP and JZ go to FETCH, so each takes 2 cycles. A taken jump overwrites the incremented pc.
  - EXEC, IN: if the FIFO is non-empty, pop, write rd, go to FETCH. Otherwise go to WAIT_IN.
  - WAIT_IN: pop and write rd on the first cycle the FIFO is non-empty, then go to FETCH.
  - EXEC, OUT: register tx_data<=rs[7:0] and tx_valid<=1; go to WAIT_OUT.
  - WAIT_OUT: the transfer happens on the cycle where tx_valid && tx_ready. On that edge tx_valid<=0 and the state goes to FETCH. tx_data is stable while tx_valid=1. Minimum OUT cost is 3 cycles.
  - EXEC, HALT: go to HALT and set halted=1. HALT is terminal until reset; pc is frozen at HALT address+1. The FIFO continues to accept bytes.
- RX FIFO:
  - Push on rx_valid when count<RX_DEPTH, or when a pop occurs in the same cycle.
  - Otherwise the byte is dropped and rx_overflow is set; it stays set until reset.
  - Simultaneous push and pop with the FIFO empty is not possible: a pop requires non-empty.
  - A pop and push in the same cycle leave count unchanged. Pointers wrap modulo RX_DEPTH. Order is FIFO.
- dbg_data is a pure combinational read and has no side effects.

Test Plan:
- ALU/OUT sequence: rst, then program LDI r0,5; LDI r1,3; ADD r0,r1; OUT r0 with tx_ready=1 -> tx_valid rises at cycle 8 after reset release with tx_data=0x08, held 1 cycle. Then SUB r0,r1; OUT r0 -> tx_data=0x05. SUB giving r0=0-1 -> 0xFF (DATA_W=8).
- IN stall: IN r2 with FIFO empty -> core holds in WAIT_IN and pc does not advance. Pulse rx_valid with 0x41 -> r2=0x41 one cycle later; next instruction fetched on the following cycle.
- Overflow: 5 rx_valid pulses (0x10..0x14) with no IN, RX_DEPTH=4 -> rx_overflow=1. Then 4 IN instructions return 0x10,0x11,0x12,0x13 in order; 0x14 is lost.
- TX backpressure: OUT with tx_ready=0 for 10 cycles -> tx_valid stays 1 and tx_data is constant. tx_ready=1 -> tx_valid=0 on the next edge.
- Control flow: LDI r3,0; JZ r3,0x10 -> next fetch address 0x10. JMP 0xFF then NOP at 0xFF -> pc wraps to 0x00. HALT -> halted=1 and instr_addr frozen.
- Reset mid-stall: assert rst while in WAIT_OUT with tx_valid=1 -> tx_valid=0, halted=0, rx_overflow=0, instr_addr=0 immediately, without waiting for a clock edge.
